load_store_unit: RTL and testbench

- Sits between the EX stage and Data_Memory. It turns RISC-V load/store requests (b/h/w/d, signed and unsigned) into the memory's 64-bit byte-addressed window accesses.
- Sub-doubleword stores use read-modify-write: read an 8-byte aligned window, merge the byte lanes, write the window back.
- Loads are extracted and extended before being returned to the pipeline through a ready/valid handshake.

---
 rtl/load_store_unit_pkg.sv | 33 +++
 rtl/lsu_lane_unit.sv | 34 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and decode helpers for the load/store unit.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_MW,
    ST_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [2:0] F3_XX = 3'b111;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return '1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte-lane datapath: merges store bytes into a window and extracts/extends load bytes.
module lsu_lane_unit
  import load_store_unit_pkg::*;
(
  input  logic [63:0] window_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] store_win_o,
  output logic [63:0] load_val_o
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] mask;

  assign shamt = {lane_i, 3'b000};

  always_comb begin
    shifted     = window_i >> shamt;
    mask        = lane_mask(funct3_i[1:0]);
    store_win_o = (window_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
    case (funct3_i)
      F3_B:    load_val_o = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    load_val_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_val_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   load_val_o = {56'd0, shifted[7:0]};
      F3_HU:   load_val_o = {48'd0, shifted[15:0]};
      F3_WU:   load_val_o = {32'd0, shifted[31:0]};
      default: load_val_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: RISC-V b/h/w/d accesses mapped onto 64-bit aligned memory windows,
// with read-modify-write for sub-doubleword stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = 16,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] WriteData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] Read_Data
);

  lsu_state_e        state_q;
  logic              ready_q, resp_valid_q, resp_err_q, mem_read_q, mem_write_q;
  logic [DATA_W-1:0] load_data_q, wdata_out_q, wdata_q;
  logic [ADDR_W-1:0] mem_addr_q, base_q;
  logic              is_store_q;
  logic [2:0]        funct3_q, lane_q;

  logic [2:0]        align_m;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_base;
  logic [63:0]       store_win, load_val;

  always_comb begin
    align_m  = 3'(size_bytes(req_funct3[1:0]) - 4'd1);
    acc_base = req_addr & ~ADDR_W'(7);
    acc_err  = (req_addr >= ADDR_W'(MEM_BYTES))
            || ((req_addr[2:0] & align_m) != 3'b000)
            || (req_is_store && req_funct3[2])
            || (!req_is_store && req_funct3 == F3_XX);
  end

  // Read_Data is only valid during RD, which is exactly when the lane outputs are consumed.
  lsu_lane_unit u_lane (
    .window_i    (Read_Data),
    .wdata_i     (wdata_q),
    .lane_i      (lane_q),
    .funct3_i    (funct3_q),
    .store_win_o (store_win),
    .load_val_o  (load_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      wdata_out_q  <= '0;
      load_data_q  <= '0;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      lane_q       <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      wdata_out_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            base_q     <= acc_base;
            lane_q     <= req_addr[2:0];
            wdata_q    <= req_wdata;
            ready_q    <= 1'b0;
            if (acc_err) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_is_store && req_funct3 == F3_D) begin
              state_q     <= ST_MW;
              mem_write_q <= 1'b1;
              mem_addr_q  <= acc_base;
              wdata_out_q <= req_wdata;
            end else begin
              state_q    <= ST_RD;
              mem_read_q <= 1'b1;
              mem_addr_q <= acc_base;
            end
          end
        end
        ST_RD: begin
          if (is_store_q) begin
            state_q     <= ST_MW;
            mem_write_q <= 1'b1;
            mem_addr_q  <= base_q;
            wdata_out_q <= store_win;
          end else begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            load_data_q  <= load_val;
          end
        end
        ST_MW: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign load_data  = load_data_q;
  assign Mem_Addr   = mem_addr_q;
  assign WriteData  = wdata_out_q;
  assign memRead    = mem_read_q;
  assign memWrite   = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

  localparam int MEM_BYTES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] load_data, Mem_Addr, WriteData, Read_Data;
  logic        memRead, memWrite;

  logic [7:0] dmem[MEM_BYTES];
  logic [7:0] ref_mem[MEM_BYTES];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .load_data(load_data), .Mem_Addr(Mem_Addr), .WriteData(WriteData),
    .memRead(memRead), .memWrite(memWrite), .Read_Data(Read_Data)
  );

  // Data_Memory stand-in: combinational read, write at the clock edge.
  always_comb begin
    Read_Data = '0;
    for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = dmem[int'({Mem_Addr[3], 3'b000}) + i];
  end

  always @(posedge clk) begin
    if (memWrite)
      for (int i = 0; i < 8; i++) dmem[int'({Mem_Addr[3], 3'b000}) + i] = WriteData[8*i +: 8];
  end

  // ---------------- reference model ----------------
  function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [63:0] addr);
    int sz = 1 << f3[1:0];
    return (addr >= 64'(MEM_BYTES)) || ((addr % 64'(sz)) != 0) || (st && f3 >= 3'd4) || (!st && f3 == 3'd7);
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr);
    int sz = 1 << f3[1:0];
    logic [63:0] v = '0;
    for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
    if (f3 < 3'd3 && v[8*sz-1]) v = v | ('1 << (8 * sz));
    return v;
  endfunction

  function automatic logic [63:0] ref_window(input logic [63:0] addr);
    logic [63:0] v = '0;
    int b = int'(addr) / 8 * 8;
    for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[b + i]) << (8 * i));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
    int sz = 1 << f3[1:0];
    for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd,
                       output int lat, output logic err, output logic [63:0] ld,
                       output int nrd, output int nwr, output logic [63:0] rd_addr,
                       output logic [63:0] wr_addr, output logic [63:0] wr_data, output logic busy_ok);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; err = 1'bx; ld = 'x; nrd = 0; nwr = 0;
    rd_addr = 'x; wr_addr = 'x; wr_data = 'x; busy_ok = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      if (!memRead && !memWrite && (Mem_Addr !== 64'd0 || WriteData !== 64'd0)) busy_ok = 1'b0;
      if (memRead) begin nrd++; rd_addr = Mem_Addr; end
      if (memWrite) begin nwr++; wr_addr = Mem_Addr; wr_data = WriteData; end
      if (resp_valid) begin lat = c; err = resp_err; ld = load_data; break; end
    end
  endtask

  task automatic load_image();
    logic [7:0] img[MEM_BYTES] = '{8'h83, 8'h34, 8'h05, 8'h0F, 8'hB3, 8'h84, 8'h9A, 8'h00,
                                   8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h38, 8'h95, 8'h0E};
    for (int i = 0; i < MEM_BYTES; i++) begin dmem[i] = img[i]; ref_mem[i] = img[i]; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_err, memRead, memWrite} !== 5'b10000) begin
      n_err++; $display("FAIL reset_ctrl: got %b exp 10000", {req_ready, resp_valid, resp_err, memRead, memWrite});
    end
    n_vec++;
    if (Mem_Addr !== 64'd0 || WriteData !== 64'd0 || load_data !== 64'd0) begin
      n_err++; $display("FAIL reset_data: got addr=%h wd=%h ld=%h exp all 0", Mem_Addr, WriteData, load_data);
    end
  endtask

  task automatic test_directed();
    int lat, nrd, nwr; logic err, bok; logic [63:0] ld, ra, wa, wdt;
    // loads: funct3, addr, expected
    logic [2:0]  lf[4] = '{3'b011, 3'b000, 3'b100, 3'b001};
    logic [63:0] la[4] = '{64'd0, 64'd0, 64'd0, 64'd4};
    logic [63:0] le[4] = '{64'h009A84B3_0F053483, 64'hFFFFFFFF_FFFFFF83,
                           64'h00000000_00000083, 64'hFFFFFFFF_FFFF84B3};
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, lf[k], la[k], 64'd0, lat, err, ld, nrd, nwr, ra, wa, wdt, bok);
      n_vec++;
      if (lat !== 2 || err !== 1'b0 || ld !== le[k]) begin
        n_err++; $display("FAIL plan_load%0d: got lat=%0d err=%b data=%h exp lat=2 err=0 data=%h", k, lat, err, ld, le[k]);
      end
      n_vec++;
      if (nrd !== 1 || nwr !== 0 || ra !== (la[k] & ~64'd7)) begin
        n_err++; $display("FAIL plan_load%0d_mem: got rd=%0d wr=%0d addr=%h exp rd=1 wr=0 addr=%h", k, nrd, nwr, ra, la[k] & ~64'd7);
      end
    end
    issue(1'b1, 3'b000, 64'd9, 64'h12345678_9ABCDEAA, lat, err, ld, nrd, nwr, ra, wa, wdt, bok);
    ref_store(3'b000, 64'd9, 64'h12345678_9ABCDEAA);
    n_vec++;
    if (lat !== 3 || err !== 1'b0 || nrd !== 1 || ra !== 64'd8) begin
      n_err++; $display("FAIL plan_sb: got lat=%0d err=%b rd=%0d raddr=%h exp lat=3 err=0 rd=1 raddr=8", lat, err, nrd, ra);
    end
    n_vec++;
    if (nwr !== 1 || wa !== 64'd8 || wdt !== 64'h0E953823_0014AA93) begin
      n_err++; $display("FAIL plan_sb_write: got wr=%0d addr=%h data=%h exp 1 8 0e9538230014aa93", nwr, wa, wdt);
    end
    issue(1'b0, 3'b011, 64'd8, 64'd0, lat, err, ld, nrd, nwr, ra, wa, wdt, bok);
    n_vec++;
    if (ld !== 64'h0E953823_0014AA93 || err !== 1'b0) begin
      n_err++; $display("FAIL plan_ld8: got %h err=%b exp 0e9538230014aa93 err=0", ld, err);
    end
  endtask

  task automatic test_errors();
    int lat, nrd, nwr; logic err, bok; logic [63:0] ld, ra, wa, wdt;
    logic        es[3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  ef[3] = '{3'b010, 3'b011, 3'b100};
    logic [63:0] ea[3] = '{64'd2, 64'd16, 64'd0};
    for (int k = 0; k < 3; k++) begin
      issue(es[k], ef[k], ea[k], 64'hFFFF_FFFF_FFFF_FFFF, lat, err, ld, nrd, nwr, ra, wa, wdt, bok);
      n_vec++;
      if (lat !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0) begin
        n_err++; $display("FAIL err_case%0d: got lat=%0d err=%b rd=%0d wr=%0d exp 1 1 0 0", k, lat, err, nrd, nwr);
      end
    end
  endtask

  task automatic test_random();
    int lat, nrd, nwr; logic err, bok; logic [63:0] ld, ra, wa, wdt;
    logic st; logic [2:0] f3; logic [63:0] addr, wd;
    int x_lat, x_rd, x_wr; logic x_err; logic [63:0] x_ld, x_wd;
    for (int it = 0; it < 60; it++) begin
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(16, 100)) : 64'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      wd   = {$urandom, $urandom};
      x_err = ref_err(st, f3, addr);
      x_lat = x_err ? 1 : (!st ? 2 : (f3 == 3'd3 ? 2 : 3));
      x_rd  = (x_err || (st && f3 == 3'd3)) ? 0 : 1;
      x_wr  = (!x_err && st) ? 1 : 0;
      x_ld  = (!x_err && !st) ? ref_load(f3, addr) : 64'd0;
      if (!x_err && st) ref_store(f3, addr, wd);
      x_wd  = (!x_err && st) ? ref_window(addr) : 64'd0;
      issue(st, f3, addr, wd, lat, err, ld, nrd, nwr, ra, wa, wdt, bok);
      n_vec++;
      if (lat !== x_lat || err !== x_err || nrd !== x_rd || nwr !== x_wr || bok !== 1'b1) begin
        n_err++; $display("FAIL rand%0d_ctl st=%b f3=%0d a=%0d: got lat=%0d err=%b rd=%0d wr=%0d busy=%b exp %0d %b %0d %0d 1",
                          it, st, f3, addr, lat, err, nrd, nwr, bok, x_lat, x_err, x_rd, x_wr);
      end
      if (!x_err && !st) begin
        n_vec++;
        if (ld !== x_ld || ra !== (addr & ~64'd7)) begin
          n_err++; $display("FAIL rand%0d_load f3=%0d a=%0d: got %h raddr=%h exp %h", it, f3, addr, ld, ra, x_ld);
        end
      end
      if (!x_err && st) begin
        n_vec++;
        if (wdt !== x_wd || wa !== (addr & ~64'd7)) begin
          n_err++; $display("FAIL rand%0d_store f3=%0d a=%0d: got %h waddr=%h exp %h", it, f3, addr, wdt, wa, x_wd);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, nrd, nwr; logic err, bok; logic [63:0] ld, ra, wa, wdt;
    logic seen_resp = 1'b0; logic hit_mw = 1'b0; logic [63:0] wd = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'd8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (memRead !== 1'b1) begin n_err++; $display("FAIL mid_rd: got memRead=%b exp 1", memRead); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({req_ready, resp_valid, memRead, memWrite} !== 4'b1000 || Mem_Addr !== 64'd0 || WriteData !== 64'd0) begin
      n_err++; $display("FAIL mid_reset: got ctl=%b addr=%h wd=%h exp 1000 0 0", {req_ready, resp_valid, memRead, memWrite}, Mem_Addr, WriteData);
    end
    repeat (4) begin @(negedge clk); if (resp_valid || memRead || memWrite) seen_resp = 1'b1; end
    n_vec++;
    if (seen_resp !== 1'b0) begin n_err++; $display("FAIL mid_quiet: got activity=1 exp 0"); end
    // reset landing on the MW edge of a sub-word store: the write must still commit
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b001; req_addr = 64'd6; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (memWrite) begin hit_mw = 1'b1; break; end
    end
    n_vec++;
    if (hit_mw !== 1'b1) begin n_err++; $display("FAIL mid_mw_seen: got 0 exp 1"); end
    reset = 1'b1;
    ref_store(3'b001, 64'd6, wd);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 3'b011, 64'd0, 64'd0, lat, err, ld, nrd, nwr, ra, wa, wdt, bok);
    n_vec++;
    if (ld !== ref_window(64'd0) || err !== 1'b0) begin
      n_err++; $display("FAIL mid_mw_commit: got %h err=%b exp %h", ld, err, ref_window(64'd0));
    end
  endtask

  task automatic test_back_to_back();
    logic rdy_exp[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic rv_exp[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b100; req_addr = 64'd5;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_ready !== rdy_exp[c] || resp_valid !== rv_exp[c]) begin
        n_err++; $display("FAIL b2b_cycle%0d: got ready=%b resp=%b exp ready=%b resp=%b", c, req_ready, resp_valid, rdy_exp[c], rv_exp[c]);
      end
    end
    req_valid = 1'b0;
    n_vec++;
    if (load_data !== ref_load(3'b100, 64'd5)) begin
      n_err++; $display("FAIL b2b_data: got %h exp %h", load_data, ref_load(3'b100, 64'd5));
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    load_image();
    test_reset();
    test_directed();
    test_errors();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
